vec_strided_lsu: RTL and testbench
==================================

Name: vec_strided_lsu

Overview:
Parametrised strided load/store engine for the vector coprocessor. It takes one vlse.v/vsse.v-style request (base, signed byte stride, vl, SEW) and walks the elements one memory transaction at a time on the coprocessor's mem_valid/mem_ready port. SEW 8/16/32 are handled by byte-lane packing. Load results are packed into a vector-register-wide result bus.

Parameters:
MAX_VL, 32, maximum element count per request; larger req_vl is clamped to MAX_VL.
VREG_W, 256, width of packed vector data (must be >= MAX_VL*8).
VLW, $clog2(MAX_VL+1), width of req_vl.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request strobe
req_ready  out  1  high only in IDLE
req_store  in  1  1=store, 0=load
req_base  in  32  byte address of element 0
req_stride  in  32  signed byte stride
req_vl  in  VLW  element count
req_sew  in  2  0=e8, 1=e16, 2=e32, 3=reserved
req_wdata  in  VREG_W  store elements packed at SEW, element 0 in LSBs
rdata  out  VREG_W  loaded elements packed at SEW
done  out  1  one-cycle completion pulse
err  out  1  valid with done: reserved SEW or misaligned element
mem_valid  out  1  memory request
mem_ready  in  1  memory acknowledge
mem_addr  out  32  word-aligned address
mem_wdata  out  32  store data, lane-shifted
mem_wstrb  out  4  byte strobes; 0 for loads
mem_rdata  in  32  load data

Behaviour:
- Reset (synchronous, active-high): state IDLE. req_ready=1. done, err, mem_valid=0. mem_addr, mem_wdata, mem_wstrb=0. rdata=0. Any in-flight transaction is abandoned.
- FSM states: IDLE, CHECK, ACCESS, FIN.
- IDLE:
  - Request accepted on the edge where req_valid && req_ready.
  - Latches all req_* fields, with vl clamped to MAX_VL. A load clears rdata. Element index i=0, addr=req_base.
  - Next state is CHECK.
- CHECK (1 cycle per element):
  - If sew==3, or addr is not a multiple of the element size (e16: addr[0]!=0; e32: addr[1:0]!=0): err<=1, go to FIN. No memory access is issued for that element.
  - Else if i==vl (this covers vl==0): go to FIN.
  - Else: drive mem_valid=1 and mem_addr={addr[31:2],2'b00}.
    - Store: mem_wdata = element i shifted left by 8*addr[1:0], other lanes 0. mem_wstrb = (e8 4'b0001, e16 4'b0011, e32 4'b1111) << addr[1:0].
    - Load: mem_wstrb=0.
  - Go to ACCESS.
- ACCESS:
  - mem_valid, mem_addr, mem_wdata and mem_wstrb are held stable until mem_ready is sampled high.
  - On that edge: mem_valid<=0. A load writes bytes mem_rdata>>(8*addr[1:0]), SEW bits wide, into rdata element i. Then i<=i+1, addr<=addr+stride (32-bit wrap, stride is two's complement), go to CHECK.
  - mem_valid is therefore low for at least one cycle between elements. Throughput is 2 cycles per element plus memory latency.
- FIN: done=1 for exactly one cycle, err valid alongside it, then IDLE. req_ready returns to 1 in the IDLE cycle.
- On error, rdata keeps the elements loaded before the faulting one. Later elements stay 0. Stores already issued are not undone.
- rdata holds its value until the next load is accepted. Bits above vl*SEW read 0.
- req_* inputs are ignored outside IDLE.
- Latency with a one-cycle-ready memory: accept edge, then per element CHECK + request + ready cycles, then FIN.

Test Plan:
- Memory words 100..112 (byte addr 400..) = 04030201, 08070605, 0c0b0a09, 000f0e0d, 14131211, 18171615, 1c1b1a19, 101f1e1d, 24232221, 28272625, 0000000a, 00000014, 0000001e. Load e8, base 400, stride 10, vl 6 -> rdata[47:0]=48'h000a1f150b01, err=0, exactly 6 mem_valid transactions, all mem_wstrb=0.
- Load e16, base 400, stride 4, vl 3 -> rdata[47:0]=48'h0a0906050201.
- Load e32, base 412, stride -4 (32'hfffffffc), vl 3 -> rdata[95:0]={0c0b0a09... order: elem0=000f0e0d, elem1=0c0b0a09, elem2=08070605}, mem_addr sequence 412, 408, 404.
- Store e8, base 600, stride 10, vl 2, req_wdata[15:0]=16'hBBAA:
  - transaction 1: mem_addr=600, wstrb=0001, wdata=000000AA
  - transaction 2: mem_addr=608, wstrb=0100, wdata=00BB0000
  - afterwards word 150 byte0=AA and word 152 byte2=BB, all other bytes unchanged.
- Error and empty cases:
  - Load e32 base 402 -> done with err=1, no mem_valid ever asserted.
  - req_sew=3 -> done with err=1.
  - vl=0 -> done 2 cycles after accept, err=0, no mem_valid.
- Assert reset while in ACCESS of a 4-element load -> the next cycle shows mem_valid=0, done=0, req_ready=1, rdata=0. A following request completes normally.

Source files
------------

// File: rtl/vec_strided_lsu.sv
// Strided vector load/store engine.
// Accepts one strided request (base, signed byte stride, element count, SEW)
// and walks the elements one memory transaction at a time. Each element is
// checked for a legal SEW and natural alignment before its access is issued.
// Loaded elements are packed at SEW into a vector-register-wide result bus.

module vec_strided_lsu #(
    parameter int MAX_VL = 32,
    parameter int VREG_W = 256,
    parameter int VLW    = $clog2(MAX_VL + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [31:0]       req_base,
    input  logic [31:0]       req_stride,
    input  logic [VLW-1:0]    req_vl,
    input  logic [1:0]        req_sew,
    input  logic [VREG_W-1:0] req_wdata,
    output logic [VREG_W-1:0] rdata,
    output logic              done,
    output logic              err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        ACCESS,
        FIN
    } state_t;

    localparam logic [VLW-1:0] VL_MAX = VLW'(MAX_VL);

    state_t            state;
    logic              store_q;
    logic [31:0]       addr_q;
    logic [31:0]       stride_q;
    logic [VLW-1:0]    vl_q;
    logic [1:0]        sew_q;
    logic [VLW-1:0]    idx_q;
    logic [VREG_W-1:0] wdata_q;

    // Per-element decode derived from the latched SEW and current address.
    logic [31:0]    elem_mask;   // SEW-wide mask in the low bits
    logic [3:0]     elem_strb;   // unshifted byte strobe for one element
    logic           elem_fault;  // reserved SEW or misaligned element
    logic [VLW+4:0] elem_shamt;  // bit offset of element idx_q in the packed bus
    logic [4:0]     lane_shamt;  // bit offset of the element within a memory word
    logic [31:0]    store_elem;
    logic [31:0]    load_elem;
    logic [VREG_W-1:0] load_ins;

    assign req_ready = (state == IDLE);

    // Decode element size, strobe, alignment fault and packed-bus offset.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        elem_mask  = 32'h0000_0000;
        elem_strb  = 4'b0000;
        elem_fault = 1'b1;
        elem_shamt = '0;
        case (sew_q)
            2'd0: begin
                elem_mask  = 32'h0000_00ff;
                elem_strb  = 4'b0001;
                elem_fault = 1'b0;
                elem_shamt = {2'b00, idx_q, 3'b000};
            end
            2'd1: begin
                elem_mask  = 32'h0000_ffff;
                elem_strb  = 4'b0011;
                elem_fault = addr_q[0];
                elem_shamt = {1'b0, idx_q, 4'b0000};
            end
            2'd2: begin
                elem_mask  = 32'hffff_ffff;
                elem_strb  = 4'b1111;
                elem_fault = |addr_q[1:0];
                elem_shamt = {idx_q, 5'b00000};
            end
            default: begin
                elem_mask  = 32'h0000_0000;
                elem_strb  = 4'b0000;
                elem_fault = 1'b1;
                elem_shamt = '0;
            end
        endcase
    end

    // Lane positioning for the store element and the returned load data.
    // Elements whose packed offset falls beyond VREG_W shift out to zero.
    assign lane_shamt = {addr_q[1:0], 3'b000};
    assign store_elem = 32'(wdata_q >> elem_shamt) & elem_mask;
    assign load_elem  = (mem_rdata >> lane_shamt) & elem_mask;
    assign load_ins   = VREG_W'(load_elem) << elem_shamt;

    // Store data capture; only read after a store has been accepted.
    always_ff @(posedge clk) begin
        // NOTE: this wide datapath register has no reset: it is always written on accept before use.
        if (req_valid && req_ready && req_store) begin
            wdata_q <= req_wdata;
        end
    end

    // Request sequencing: accept, per-element check/issue, wait for ack, finish.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state     <= IDLE;
            store_q   <= 1'b0;
            addr_q    <= 32'h0;
            stride_q  <= 32'h0;
            vl_q      <= '0;
            sew_q     <= 2'd0;
            idx_q     <= '0;
            rdata     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_valid <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'b0000;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        store_q  <= req_store;
                        addr_q   <= req_base;
                        stride_q <= req_stride;
                        vl_q     <= (req_vl > VL_MAX) ? VL_MAX : req_vl;
                        sew_q    <= req_sew;
                        idx_q    <= '0;
                        if (!req_store) begin
                            rdata <= '0;
                        end
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (elem_fault) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= FIN;
                    end else if (idx_q == vl_q) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        mem_valid <= 1'b1;
                        mem_addr  <= {addr_q[31:2], 2'b00};
                        if (store_q) begin
                            mem_wdata <= store_elem << lane_shamt;
                            mem_wstrb <= elem_strb << addr_q[1:0];
                        end else begin
                            mem_wdata <= 32'h0;
                            mem_wstrb <= 4'b0000;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if (!store_q) begin
                            rdata <= rdata | load_ins;
                        end
                        idx_q  <= idx_q + VLW'(1);
                        addr_q <= addr_q + stride_q;
                        state  <= CHECK;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_strided_lsu.sv
// Directed testbench for vec_strided_lsu with a word-addressed memory model
// that acknowledges each request after one wait cycle.

module tb_vec_strided_lsu;

    localparam int MAX_VL = 32;
    localparam int VREG_W = 256;
    localparam int VLW    = $clog2(MAX_VL + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [31:0]       req_base;
    logic [31:0]       req_stride;
    logic [VLW-1:0]    req_vl;
    logic [1:0]        req_sew;
    logic [VREG_W-1:0] req_wdata;
    logic [VREG_W-1:0] rdata;
    logic              done;
    logic              err;
    logic              mem_valid;
    logic              mem_ready;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vec_strided_lsu #(.MAX_VL(MAX_VL), .VREG_W(VREG_W), .VLW(VLW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_store (req_store),
        .req_base  (req_base),
        .req_stride(req_stride),
        .req_vl    (req_vl),
        .req_sew   (req_sew),
        .req_wdata (req_wdata),
        .rdata     (rdata),
        .done      (done),
        .err       (err),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    // Memory model: initialised under reset, ack one cycle after request.
    logic [31:0] mem [0:255];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[100] <= 32'h04030201; mem[101] <= 32'h08070605;
            mem[102] <= 32'h0c0b0a09; mem[103] <= 32'h000f0e0d;
            mem[104] <= 32'h14131211; mem[105] <= 32'h18171615;
            mem[106] <= 32'h1c1b1a19; mem[107] <= 32'h101f1e1d;
            mem[108] <= 32'h24232221; mem[109] <= 32'h28272625;
            mem[110] <= 32'h0000000a; mem[111] <= 32'h00000014;
            mem[112] <= 32'h0000001e;
            mem[150] <= 32'h11223344; mem[151] <= 32'h55667788;
            mem[152] <= 32'h99aabbcc;
            mem_ready <= 1'b0;
        end else begin
            mem_ready <= mem_valid && !mem_ready;
            if (mem_valid && mem_ready) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    assign mem_rdata = mem[mem_addr[9:2]];

    // Transaction monitor: logs every handshake and counts mem_valid cycles.
    int          hs_count     = 0;
    int          valid_cycles = 0;
    logic [31:0] log_addr  [0:127];
    logic [31:0] log_wdata [0:127];
    logic [3:0]  log_strb  [0:127];

    always @(posedge clk) begin
        if (mem_valid === 1'b1) valid_cycles <= valid_cycles + 1;
        if (mem_valid === 1'b1 && mem_ready === 1'b1) begin
            log_addr[hs_count[6:0]]  <= mem_addr;
            log_wdata[hs_count[6:0]] <= mem_wdata;
            log_strb[hs_count[6:0]]  <= mem_wstrb;
            hs_count <= hs_count + 1;
        end
    end

    task automatic start_req(input logic st, input logic [31:0] base, input logic [31:0] stride,
                             input logic [VLW-1:0] vl, input logic [1:0] sew,
                             input logic [VREG_W-1:0] wd);
        @(negedge clk);
        req_store  = st;
        req_base   = base;
        req_stride = stride;
        req_vl     = vl;
        req_sew    = sew;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    // Returns the negedge index (accept edge's negedge = 1) at which done is seen.
    task automatic wait_done(input int limit, output int cycles, output logic seen);
        cycles = 1;
        while (done !== 1'b1 && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
        seen = (done === 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        n_checks++; if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_done_err got=%b%b exp=00", done, err); end
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); end
        n_checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin
            n_fail++; $display("FAIL reset_mem_bus got=%h/%h/%h exp=0", mem_addr, mem_wdata, mem_wstrb); end
        n_checks++; if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        reset = 1'b0;
    endtask

    task automatic test_load_e8();
        int cyc; logic seen; int hs0; logic strb_ok;
        hs0 = hs_count;
        start_req(1'b0, 32'd400, 32'd10, VLW'(6), 2'd0, '0);
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL e8_busy_ready got=%b exp=0", req_ready); end
        wait_done(100, cyc, seen);
        n_checks++; if (!seen || cyc != 20) begin n_fail++; $display("FAIL e8_latency got=%0d seen=%b exp=20", cyc, seen); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL e8_err got=%b exp=0", err); end
        n_checks++; if (rdata !== VREG_W'(48'h000a1f150b01)) begin n_fail++; $display("FAIL e8_rdata got=%h exp=000a1f150b01", rdata); end
        n_checks++; if (hs_count - hs0 != 6) begin n_fail++; $display("FAIL e8_txn_count got=%0d exp=6", hs_count - hs0); end
        strb_ok = 1'b1;
        for (int i = hs0; i < hs_count; i++) if (log_strb[i[6:0]] !== 4'b0000) strb_ok = 1'b0;
        n_checks++; if (!strb_ok) begin n_fail++; $display("FAIL e8_load_wstrb got=nonzero exp=0000"); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL e8_done_pulse got done=%b ready=%b exp done=0 ready=1", done, req_ready); end
    endtask

    task automatic test_load_e16();
        int cyc; logic seen;
        start_req(1'b0, 32'd400, 32'd4, VLW'(3), 2'd1, '0);
        wait_done(100, cyc, seen);
        n_checks++; if (!seen || cyc != 11 || err !== 1'b0) begin
            n_fail++; $display("FAIL e16_done got cyc=%0d seen=%b err=%b exp cyc=11 err=0", cyc, seen, err); end
        n_checks++; if (rdata !== VREG_W'(48'h0a0906050201)) begin n_fail++; $display("FAIL e16_rdata got=%h exp=0a0906050201", rdata); end
    endtask

    task automatic test_load_e32();
        int cyc; logic seen; int hs0;
        hs0 = hs_count;
        start_req(1'b0, 32'd412, 32'hfffffffc, VLW'(3), 2'd2, '0);
        wait_done(100, cyc, seen);
        n_checks++; if (!seen || err !== 1'b0) begin n_fail++; $display("FAIL e32_done got seen=%b err=%b exp seen=1 err=0", seen, err); end
        n_checks++; if (rdata !== VREG_W'(96'h08070605_0c0b0a09_000f0e0d)) begin
            n_fail++; $display("FAIL e32_rdata got=%h exp=080706050c0b0a09000f0e0d", rdata); end
        n_checks++; if (hs_count - hs0 != 3 || log_addr[hs0[6:0]] !== 32'd412 ||
                        log_addr[6'(hs0 + 1)] !== 32'd408 || log_addr[6'(hs0 + 2)] !== 32'd404) begin
            n_fail++; $display("FAIL e32_addr_seq got n=%0d %0d,%0d,%0d exp n=3 412,408,404", hs_count - hs0,
                               log_addr[hs0[6:0]], log_addr[6'(hs0 + 1)], log_addr[6'(hs0 + 2)]); end
    endtask

    task automatic test_store_e8();
        int cyc; logic seen; int hs0;
        hs0 = hs_count;
        start_req(1'b1, 32'd600, 32'd10, VLW'(2), 2'd0, VREG_W'(16'hbbaa));
        wait_done(100, cyc, seen);
        n_checks++; if (!seen || cyc != 8 || err !== 1'b0) begin
            n_fail++; $display("FAIL st_done got cyc=%0d seen=%b err=%b exp cyc=8 err=0", cyc, seen, err); end
        n_checks++; if (hs_count - hs0 != 2) begin n_fail++; $display("FAIL st_txn_count got=%0d exp=2", hs_count - hs0); end
        n_checks++; if (log_addr[hs0[6:0]] !== 32'd600 || log_strb[hs0[6:0]] !== 4'b0001 || log_wdata[hs0[6:0]] !== 32'h000000aa) begin
            n_fail++; $display("FAIL st_txn1 got addr=%0d strb=%b wdata=%h exp 600/0001/000000aa",
                               log_addr[hs0[6:0]], log_strb[hs0[6:0]], log_wdata[hs0[6:0]]); end
        n_checks++; if (log_addr[6'(hs0 + 1)] !== 32'd608 || log_strb[6'(hs0 + 1)] !== 4'b0100 || log_wdata[6'(hs0 + 1)] !== 32'h00bb0000) begin
            n_fail++; $display("FAIL st_txn2 got addr=%0d strb=%b wdata=%h exp 608/0100/00bb0000",
                               log_addr[6'(hs0 + 1)], log_strb[6'(hs0 + 1)], log_wdata[6'(hs0 + 1)]); end
        n_checks++; if (mem[150] !== 32'h112233aa || mem[151] !== 32'h55667788 || mem[152] !== 32'h99bbbbcc) begin
            n_fail++; $display("FAIL st_mem got=%h,%h,%h exp=112233aa,55667788,99bbbbcc", mem[150], mem[151], mem[152]); end
        n_checks++; if (rdata !== VREG_W'(96'h08070605_0c0b0a09_000f0e0d)) begin
            n_fail++; $display("FAIL st_rdata_hold got=%h exp=080706050c0b0a09000f0e0d", rdata); end
    endtask

    task automatic test_errors();
        int cyc; logic seen; int v0;
        // Misaligned e32
        v0 = valid_cycles;
        start_req(1'b0, 32'd402, 32'd4, VLW'(2), 2'd2, '0);
        wait_done(20, cyc, seen);
        n_checks++; if (!seen || cyc != 2 || err !== 1'b1) begin
            n_fail++; $display("FAIL misalign_err got cyc=%0d seen=%b err=%b exp cyc=2 err=1", cyc, seen, err); end
        n_checks++; if (valid_cycles != v0) begin n_fail++; $display("FAIL misalign_no_mem got=%0d exp=0", valid_cycles - v0); end
        // Reserved SEW
        v0 = valid_cycles;
        start_req(1'b0, 32'd400, 32'd4, VLW'(2), 2'd3, '0);
        wait_done(20, cyc, seen);
        n_checks++; if (!seen || err !== 1'b1) begin n_fail++; $display("FAIL sew3_err got seen=%b err=%b exp 1/1", seen, err); end
        n_checks++; if (valid_cycles != v0) begin n_fail++; $display("FAIL sew3_no_mem got=%0d exp=0", valid_cycles - v0); end
        // Empty request
        v0 = valid_cycles;
        start_req(1'b0, 32'd400, 32'd4, VLW'(0), 2'd0, '0);
        wait_done(20, cyc, seen);
        n_checks++; if (!seen || cyc != 2 || err !== 1'b0) begin
            n_fail++; $display("FAIL vl0_done got cyc=%0d seen=%b err=%b exp cyc=2 err=0", cyc, seen, err); end
        n_checks++; if (valid_cycles != v0) begin n_fail++; $display("FAIL vl0_no_mem got=%0d exp=0", valid_cycles - v0); end
        @(negedge clk);
    endtask

    task automatic test_reset_in_access();
        int cyc; logic seen; int hs0; int n;
        hs0 = hs_count;
        start_req(1'b0, 32'd400, 32'd1, VLW'(4), 2'd0, '0);
        n = 0;
        while (!(mem_valid === 1'b1 && hs_count - hs0 == 1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if (n >= 40) begin n_fail++; $display("FAIL rst_reach_access got=timeout exp=second access"); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_valid !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_access_ctrl got valid=%b done=%b ready=%b exp 0/0/1", mem_valid, done, req_ready); end
        n_checks++; if (rdata !== '0) begin n_fail++; $display("FAIL rst_access_rdata got=%h exp=0", rdata); end
        reset = 1'b0;
        start_req(1'b0, 32'd400, 32'd4, VLW'(3), 2'd1, '0);
        wait_done(100, cyc, seen);
        n_checks++; if (!seen || err !== 1'b0 || rdata !== VREG_W'(48'h0a0906050201)) begin
            n_fail++; $display("FAIL rst_followup got seen=%b err=%b rdata=%h exp 1/0/0a0906050201", seen, err, rdata); end
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_base   = 32'h0;
        req_stride = 32'h0;
        req_vl     = '0;
        req_sew    = 2'd0;
        req_wdata  = '0;
        test_reset();
        test_load_e8();
        test_load_e16();
        test_load_e32();
        test_store_e8();
        test_errors();
        test_reset_in_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
